// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM demultiplexer slice.
// - state_e     : receiver framing state (HUNT, LOCKED)
// - DEF_LANES   : default slots per frame
// - DEF_DW      : default bits per sample
// - slot_w()    : width of a slot index for a given lane count
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int DEF_LANES = 4;
  localparam int DEF_DW    = 1;

  // Never returns 0 so that a 1-lane corner still yields a legal vector.
  function automatic int slot_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Modulo-LANES slot counter for the TDM demultiplexer.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   inc      : advance one slot (wraps by natural overflow)
//   load1    : force slot to 1 (slot 0 was just consumed by a sync)
//   clr      : force slot to 0 (priority over load1 and inc)
//   slot     : current slot index
//   last     : slot is LANES-1
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int SW    = slot_w(LANES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          load1,
  input  logic          clr,
  output logic [SW-1:0] slot,
  output logic          last
);

  logic [SW-1:0] slot_q;
  logic [SW-1:0] slot_d;

  always_comb begin
    slot_d = slot_q;
    if (clr) begin
      slot_d = '0;
    end else if (load1) begin
      slot_d = SW'(1);
    end else if (inc) begin
      slot_d = slot_q + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;
  assign last = (slot_q == SW'(LANES - 1));

endmodule

// File: rtl/tdm_demux4.sv
// Time-division demultiplexer: rebuilds LANES parallel lanes from a serial
// slot stream framed by a slot-0 sync, presenting a registered frame word
// with a one-cycle valid pulse.
// Optional build macro: TDM_SYNC_CHECK_EN enables framing checks in LOCKED
// (misplaced or missing sync); without it sync_err is tied to 0.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   din         : serial sample for the current slot
//   en          : slot strobe, din/sync sampled only when high
//   sync        : marks the slot-0 sample
//   dout        : last complete frame, slot k in dout[k*DW +: DW]
//   frame_valid : one-cycle pulse when dout updates
//   locked      : receiver is frame-aligned
//   sync_err    : one-cycle pulse on a framing violation
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int DW    = DEF_DW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DW-1:0]       din,
  input  logic                en,
  input  logic                sync,
  output logic [LANES*DW-1:0] dout,
  output logic                frame_valid,
  output logic                locked,
  output logic                sync_err
);

  localparam int SW = slot_w(LANES);

  state_e              state_q, state_d;
  logic [LANES*DW-1:0] shadow_q, shadow_d;
  logic [LANES*DW-1:0] dout_q, dout_d;
  logic                fv_q, fv_d;
  logic                ctr_inc, ctr_load1, ctr_clr;
  logic [SW-1:0]       slot;
  logic                last;
`ifdef TDM_SYNC_CHECK_EN
  logic                err_q, err_d;
`endif

  tdm_slot_ctr #(
    .LANES (LANES),
    .SW    (SW)
  ) u_slot_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctr_inc),
    .load1 (ctr_load1),
    .clr   (ctr_clr),
    .slot  (slot),
    .last  (last)
  );

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    dout_d    = dout_q;
    fv_d      = 1'b0;
    ctr_inc   = 1'b0;
    ctr_load1 = 1'b0;
    ctr_clr   = 1'b0;
`ifdef TDM_SYNC_CHECK_EN
    err_d     = 1'b0;
`endif
    if (en) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            shadow_d[DW-1:0] = din;
            ctr_load1        = 1'b1;
            state_d          = LOCKED;
          end
        end
        LOCKED: begin
`ifdef TDM_SYNC_CHECK_EN
          // Early sync: realign on it, dropping the partial frame.
          if (sync && slot != '0) begin
            err_d            = 1'b1;
            shadow_d[DW-1:0] = din;
            ctr_load1        = 1'b1;
          // Missing sync at slot 0: alignment lost, go back to hunting.
          end else if (!sync && slot == '0) begin
            err_d   = 1'b1;
            ctr_clr = 1'b1;
            state_d = HUNT;
          end else
`endif
          begin
            shadow_d[slot*DW +: DW] = din;
            ctr_inc                 = 1'b1;
            // Last lane comes straight from din so the frame lands in one edge.
            if (last) begin
              dout_d = shadow_d;
              fv_d   = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      shadow_q <= '0;
      dout_q   <= '0;
      fv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      fv_q     <= fv_d;
    end
  end

`ifdef TDM_SYNC_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign sync_err = err_q;
`else
  assign sync_err = 1'b0;
`endif

  assign dout        = dout_q;
  assign frame_valid = fv_q;
  assign locked      = (state_q == LOCKED);

endmodule
